// File: rtl/addsub_pkg.sv
// Shared types for the multi-cycle add/subtract unit.
package addsub_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ADDS = 2'b10, OP_SUBS = 2'b11} op_t;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
endpackage

// File: rtl/addsub_chunk.sv
// K-bit combinational adder slice; also exposes the carry into its top bit
// so the last slice can produce the signed-overflow flag.
module addsub_chunk #(
  parameter int K = 4
) (
  input  logic [K-1:0] x,
  input  logic [K-1:0] y,
  input  logic         cin,
  output logic [K-1:0] sum,
  output logic         cout,
  output logic         c_msb
);
  logic [K:0] t;

  assign t     = {1'b0, x} + {1'b0, y} + {{K{1'b0}}, cin};
  assign sum   = t[K-1:0];
  assign cout  = t[K];
  assign c_msb = t[K-1] ^ x[K-1] ^ y[K-1];
endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract: K bits per cycle, LSB chunk first, with
// carry/overflow/zero/negative flags and optional signed saturation.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf,
  output logic         zero,
  output logic         neg
);
  localparam int NC = N / K;
  localparam int CW = (NC > 1) ? $clog2(NC) : 1;

  if (N < 2) begin : g_bad_n
    $error("addsub_seq: N must be >= 2");
  end
  if (N % K != 0) begin : g_bad_k
    $error("addsub_seq: N must be a multiple of K");
  end

  state_t        st;
  logic [N-1:0]  a_sh, b_sh;
  logic          cy, a_msb, sat_en;
  logic [CW-1:0] cnt;
  logic [K-1:0]  ch_sum;
  logic          ch_co, ch_cm;
  logic [N-1:0]  res, sat, fin;
  logic          last, v;

  addsub_chunk #(.K(K)) u_chunk (
    .x     (a_sh[K-1:0]),
    .y     (b_sh[K-1:0]),
    .cin   (cy),
    .sum   (ch_sum),
    .cout  (ch_co),
    .c_msb (ch_cm)
  );

  // Result chunks enter at the top and shift down, so after NC cycles
  // the first chunk sits in the LSBs.
  if (K == N) begin : g_one
    assign res = ch_sum;
  end else begin : g_multi
    logic [N-K-1:0] acc_hi;
    assign res = {ch_sum, acc_hi};
    always_ff @(posedge clk)
      if (st == RUN) acc_hi <= res[N-1:K];
  end

  assign last      = (cnt == CW'(NC - 1));
  assign v         = ch_cm ^ ch_co;
  assign sat       = a_msb ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  assign fin       = (sat_en && v) ? sat : res;
  assign in_ready  = (st == IDLE);
  assign out_valid = (st == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      cy     <= 1'b0;
      a_msb  <= 1'b0;
      sat_en <= 1'b0;
      cnt    <= '0;
      s      <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          a_sh   <= a;
          b_sh   <= b ^ {N{op[0]}};
          cy     <= op[0];
          a_msb  <= a[N-1];
          sat_en <= op[1];
          cnt    <= '0;
          st     <= RUN;
        end
        RUN: begin
          a_sh <= a_sh >> K;
          b_sh <= b_sh >> K;
          cy   <= ch_co;
          cnt  <= cnt + CW'(1);
          if (last) begin
            s    <= fin;
            cout <= ch_co;
            ovf  <= v;
            zero <= (fin == '0);
            neg  <= fin[N-1];
            st   <= DONE;
          end
        end
        DONE: if (out_ready) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
endmodule
